// File: rtl/vermi_spi_master.sv
// Vermibus SPI master: byte-wide shift engine with software chip select and DATA/STATUS/CONTROL/CS registers.
// Optional transfer-done interrupt enabled by defining VERMI_SPI_IRQ_EN.
module vermi_spi_master #(
  parameter logic [15:0] CLKDIV_RESET = 16'd3,
  parameter logic        CPOL_RESET   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  output logic        ready,
  input  logic [31:0] address,
  input  logic [3:0]  wstrobe,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);

  // state | meaning
  // IDLE  | sclk parked at CPOL, waiting for a DATA write
  // SHIFT | 16 sclk edges, one per half-period tick
  // DONE  | one cycle: publish rx byte, raise RXV / irq
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [15:0] div;
  logic        cpol, cpha, ie, cs, rxv, ovr;
  logic [7:0]  rx_byte, shreg;
  logic [15:0] half_cnt;
  logic [4:0]  edge_cnt;
  logic [1:0]  miso_sync;

  logic        busy, accept, wr, rd, tick;
  logic [1:0]  sel;
  logic [15:0] div_eff;
  logic [4:0]  edge_nxt;
  logic        unused;

  assign busy     = (state != IDLE);
  assign accept   = valid && !ready;
  assign wr       = accept && (wstrobe != 4'd0);
  assign rd       = accept && (wstrobe == 4'd0);
  assign sel      = address[3:2];
  assign div_eff  = (div < 16'd2) ? 16'd2 : div;
  assign tick     = (half_cnt == div_eff);
  assign edge_nxt = edge_cnt + 5'd1;
  assign spi_cs_n = ~cs;
  assign unused   = &{1'b0, address[31:4], address[1:0], wdata[31:18]};

`ifndef VERMI_SPI_IRQ_EN
  assign irq = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b0;
      rdata     <= 32'd0;
      div       <= CLKDIV_RESET;
      cpol      <= CPOL_RESET;
      cpha      <= 1'b0;
      ie        <= 1'b0;
      cs        <= 1'b0;
      rxv       <= 1'b0;
      ovr       <= 1'b0;
      rx_byte   <= 8'd0;
      shreg     <= 8'd0;
      half_cnt  <= 16'd0;
      edge_cnt  <= 5'd0;
      miso_sync <= 2'b00;
      spi_sclk  <= CPOL_RESET;
      spi_mosi  <= 1'b0;
`ifdef VERMI_SPI_IRQ_EN
      irq       <= 1'b0;
`endif
    end else begin
      miso_sync <= {miso_sync[0], spi_miso};
      ready     <= accept;
      rdata     <= 32'd0;

      if (rd) begin
        case (sel)
          2'd0: begin
            rdata <= {24'd0, rx_byte};
            rxv   <= 1'b0;
`ifdef VERMI_SPI_IRQ_EN
            irq   <= 1'b0;
`endif
          end
          2'd1: begin
            rdata <= {29'd0, ovr, rxv, busy};
            ovr   <= 1'b0;
          end
          2'd2:    rdata <= {13'd0, ie, cpha, cpol, div};
          default: rdata <= {31'd0, cs};
        endcase
      end

      if (wr) begin
        case (sel)
          2'd0: if (busy) ovr <= 1'b1;
          2'd2: if (!busy) begin
            div  <= wdata[15:0];
            cpol <= wdata[16];
            cpha <= wdata[17];
`ifdef VERMI_SPI_IRQ_EN
            ie   <= wdata[18];
`endif
          end
          2'd3:    cs <= wdata[0];
          default: ;
        endcase
      end

`ifdef VERMI_SPI_IRQ_EN
      if (!ie) irq <= 1'b0;
`endif

      case (state)
        IDLE: begin
          spi_sclk <= cpol;
          if (wr && sel == 2'd0) begin
            shreg    <= wdata[7:0];
            half_cnt <= 16'd0;
            edge_cnt <= 5'd0;
            state    <= SHIFT;
            if (!cpha) spi_mosi <= wdata[7];
          end
        end
        SHIFT: begin
          if (tick) begin
            half_cnt <= 16'd0;
            spi_sclk <= ~spi_sclk;
            edge_cnt <= edge_nxt;
            // odd edges are the first edge of each bit; CPHA picks sample vs launch on it
            if (edge_nxt[0] != cpha) shreg <= {shreg[6:0], miso_sync[1]};
            else if (cpha || edge_nxt <= 5'd14) spi_mosi <= shreg[7];
            if (edge_nxt == 5'd16) state <= DONE;
          end else begin
            half_cnt <= half_cnt + 16'd1;
          end
        end
        DONE: begin
          rx_byte <= shreg;
          rxv     <= 1'b1;
`ifdef VERMI_SPI_IRQ_EN
          if (ie) irq <= 1'b1;
`endif
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vermi_spi_master.sv
// Bench for vermi_spi_master: bus reads are scored against expectations queued when each access is issued.
module tb_vermi_spi_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic [31:0] address = 32'd0;
  logic [3:0]  wstrobe = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq, spi_sclk, spi_mosi, spi_cs_n;
  logic        loopback = 1'b1;
  logic        miso_val = 1'b0;
  logic        spi_miso;

  int n_chk = 0;
  int n_fail = 0;

  logic        sb_rd[$];
  logic [31:0] sb_exp[$];
  string       sb_tag[$];
  logic        mosi_q[$];
  int          sclk_edges = 0;

  assign spi_miso = loopback ? spi_mosi : miso_val;

  always #5 clk = ~clk;

  vermi_spi_master dut (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready), .address(address),
    .wstrobe(wstrobe), .wdata(wdata), .rdata(rdata), .irq(irq),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: pop one expectation per response strobe
  always @(negedge clk) begin
    if (ready === 1'b1 && !reset) begin
      if (sb_rd.size() == 0) begin
        chk("sb_unexpected_ready", 32'd1, 32'd0);
      end else begin
        logic        r;
        logic [31:0] e;
        string       t;
        r = sb_rd.pop_front();
        e = sb_exp.pop_front();
        t = sb_tag.pop_front();
        if (r) chk(t, rdata, e);
      end
    end
  end

  always @(posedge spi_sclk) if (spi_cs_n === 1'b0) mosi_q.push_back(spi_mosi);
  always @(spi_sclk) sclk_edges++;

  task automatic bus(input logic [1:0] reg_i, input logic wr, input logic [31:0] wd,
                     input logic score, input logic [31:0] exp, input string tag,
                     output logic [31:0] rd);
    int n;
    sb_rd.push_back(score && !wr);
    sb_exp.push_back(exp);
    sb_tag.push_back(tag);
    @(posedge clk); #1;
    valid   = 1'b1;
    address = {28'd0, reg_i, 2'b00};
    wstrobe = wr ? 4'hF : 4'h0;
    wdata   = wd;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ready !== 1'b1 && n < 16);
    rd = rdata;
    if (ready !== 1'b1) begin
      chk({tag, "_timeout"}, {31'd0, ready}, 32'd1);
      void'(sb_rd.pop_back());
      void'(sb_exp.pop_back());
      void'(sb_tag.pop_back());
    end
    valid   = 1'b0;
    wstrobe = 4'h0;
  endtask

  task automatic wr_reg(input logic [1:0] reg_i, input logic [31:0] wd);
    logic [31:0] d;
    bus(reg_i, 1'b1, wd, 1'b0, 32'd0, "wr", d);
  endtask

  task automatic rd_chk(input logic [1:0] reg_i, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    bus(reg_i, 1'b0, 32'd0, 1'b1, exp, tag, d);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] d;
    logic        done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      bus(2'd1, 1'b0, 32'd0, 1'b0, 32'd0, "poll", d);
      if (d[0] == 1'b0) done = 1'b1;
    end
    if (!done) chk({tag, "_busy_timeout"}, {31'd0, done}, 32'd1);
  endtask

  task automatic chk_mosi(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    b = 8'd0;
    chk({tag, "_nbits"}, mosi_q.size(), 32'd8);
    for (int i = 0; i < mosi_q.size() && i < 8; i++) b = {b[6:0], mosi_q[i]};
    chk({tag, "_mosi"}, {24'd0, b}, {24'd0, exp});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd_chk(2'd2, 32'h0000_0003, "rst_control");
    rd_chk(2'd1, 32'd0, "rst_status");

    // mode 0, DIV=3, loopback
    wr_reg(2'd3, 32'd1);
    chk("cs_asserted", {31'd0, spi_cs_n}, 32'd0);
    rd_chk(2'd3, 32'd1, "cs_readback");
    mosi_q.delete();
    loopback = 1'b1;
    wr_reg(2'd0, 32'h0000_00A5);
    rd_chk(2'd1, 32'd1, "m0_busy");
    wait_idle("m0");
    chk_mosi("m0", 8'hA5);
    rd_chk(2'd1, 32'd2, "m0_rxv");
    rd_chk(2'd0, 32'h0000_00A5, "m0_rx");
    rd_chk(2'd1, 32'd0, "m0_rxv_clr");

    // mode 3, DIV=2, miso held high
    wr_reg(2'd2, 32'h0003_0002);
    rd_chk(2'd2, 32'h0003_0002, "m3_control");
    chk("m3_sclk_idle", {31'd0, spi_sclk}, 32'd1);
    loopback = 1'b0;
    miso_val = 1'b1;
    mosi_q.delete();
    wr_reg(2'd0, 32'h0000_003C);
    wait_idle("m3");
    chk_mosi("m3", 8'h3C);
    chk("m3_sclk_end", {31'd0, spi_sclk}, 32'd1);
    rd_chk(2'd0, 32'h0000_00FF, "m3_rx");

    // overrun, and CONTROL write dropped while busy
    wr_reg(2'd2, 32'h0000_0003);
    loopback = 1'b1;
    mosi_q.delete();
    wr_reg(2'd0, 32'h0000_0011);
    wr_reg(2'd0, 32'h0000_0022);
    wr_reg(2'd2, 32'h0003_0009);
    rd_chk(2'd1, 32'd5, "ovr_status");
    rd_chk(2'd1, 32'd1, "ovr_cleared");
    rd_chk(2'd2, 32'h0000_0003, "ctl_drop_busy");
    wait_idle("ovr");
    chk_mosi("ovr", 8'h11);
    rd_chk(2'd0, 32'h0000_0011, "ovr_rx");

    // reset at sclk edge 5
    mosi_q.delete();
    wr_reg(2'd0, 32'h0000_00F0);
    sclk_edges = 0;
    for (int i = 0; i < 200 && sclk_edges < 5; i++) @(posedge clk);
    chk("abort_edge5_reached", {31'd0, (sclk_edges >= 5)}, 32'd1);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("abort_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("abort_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    rd_chk(2'd1, 32'd0, "abort_status");
    rd_chk(2'd0, 32'd0, "abort_rx");

    // interrupt
    wr_reg(2'd3, 32'd1);
    wr_reg(2'd2, 32'h0004_0003);
`ifdef VERMI_SPI_IRQ_EN
    rd_chk(2'd2, 32'h0004_0003, "ie_readback");
`else
    rd_chk(2'd2, 32'h0000_0003, "ie_readback");
`endif
    mosi_q.delete();
    wr_reg(2'd0, 32'h0000_005A);
    chk("irq_during", {31'd0, irq}, 32'd0);
    wait_idle("irq");
    chk_mosi("irq", 8'h5A);
`ifdef VERMI_SPI_IRQ_EN
    chk("irq_after_done", {31'd0, irq}, 32'd1);
    rd_chk(2'd1, 32'd2, "irq_status");
    chk("irq_held", {31'd0, irq}, 32'd1);
`else
    chk("irq_after_done", {31'd0, irq}, 32'd0);
`endif
    rd_chk(2'd0, 32'h0000_005A, "irq_rx");
    @(posedge clk); #1;
    chk("irq_cleared", {31'd0, irq}, 32'd0);

    repeat (4) @(posedge clk);
    chk("sb_drained", sb_rd.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
